// File: rtl/qaccel_pkg.sv
// Shared types and defaults for the quantum-core gate sequencer.
//   gate_type_t : 2-bit gate opcode
//   gate_cmd_t  : one queued gate command (type + 32-bit parameters)
//   seq_state_t : sequencer FSM states
package qaccel_pkg;

  typedef logic [1:0] gate_type_t;

  typedef struct packed {
    gate_type_t  gtype;
    logic [31:0] params;
  } gate_cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_ERROR
  } seq_state_t;

  localparam int unsigned DEFAULT_DEPTH   = 16;
  localparam int unsigned DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/gate_cmd_fifo.sv
// Synchronous FIFO of gate commands.
//   clk, rst  : clock, synchronous active-high reset
//   push      : write push_cmd (accepted when not full, or when a pop frees
//               the slot in the same cycle)
//   pop       : drop the head entry (ignored when empty)
//   flush     : empty the FIFO; wins over push and pop
//   head      : combinational view of the oldest entry
//   count     : number of stored entries
//   empty/full: count == 0 / count == DEPTH
module gate_cmd_fifo
  import qaccel_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  gate_cmd_t                push_cmd,
  input  logic                     pop,
  input  logic                     flush,
  output gate_cmd_t                head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  gate_cmd_t         mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_cmd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gate_sequencer.sv
// Issues queued gate commands to the quantum core one at a time.
//   clk, rst         : clock, synchronous active-high reset
//   push_*           : command push interface into the internal FIFO
//   run, abort       : start a run (sampled in IDLE) / stop and flush
//   busy, done_pulse : status; done_pulse marks a normally completed run
//   error            : sticky WAIT timeout flag, cleared by the next run
//   gates_executed   : saturating count of gates completed in this run
//   fifo_count       : queued entries
//   last_result      : result_data captured during the latest WAIT
//   gate_start/type/params : one-cycle issue strobe and held command
//   gate_done, result_data, result_valid : core responses
module gate_sequencer
  import qaccel_pkg::*;
#(
  parameter int unsigned DEPTH   = DEFAULT_DEPTH,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [1:0]               push_type,
  input  logic [31:0]              push_params,
  input  logic                     run,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done_pulse,
  output logic                     error,
  output logic [CNT_W-1:0]         gates_executed,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [31:0]              last_result,
  output logic                     gate_start,
  output logic [1:0]               gate_type,
  output logic [31:0]              gate_params,
  input  logic                     gate_done,
  input  logic [31:0]              result_data,
  input  logic                     result_valid
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  seq_state_t        state;
  logic [TW-1:0]     timer;
  gate_cmd_t         push_cmd;
  gate_cmd_t         head_cmd;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_flush;
  logic              fifo_empty;
  logic              fifo_full;

  assign push_cmd   = '{gtype: push_type, params: push_params};
  assign push_ready = !abort && (!fifo_full || fifo_pop);
  assign fifo_push  = push_valid && push_ready;
  assign fifo_flush = abort || (state == S_ERROR);

  // The head is popped on the edge that enters ISSUE, so the same edge
  // loads gate_type/gate_params and a full FIFO can accept a push then.
  always_comb begin
    fifo_pop = 1'b0;
    if (!abort && !fifo_empty) begin
      if (state == S_IDLE && run) begin
        fifo_pop = 1'b1;
      end else if (state == S_WAIT && gate_done) begin
        fifo_pop = 1'b1;
      end
    end
  end

  gate_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_cmd (push_cmd),
    .pop      (fifo_pop),
    .flush    (fifo_flush),
    .head     (head_cmd),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // Outputs are decoded from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      timer          <= '0;
      busy           <= 1'b0;
      done_pulse     <= 1'b0;
      error          <= 1'b0;
      gate_start     <= 1'b0;
      gate_type      <= '0;
      gate_params    <= '0;
      gates_executed <= '0;
      last_result    <= '0;
    end else begin
      gate_start <= 1'b0;
      done_pulse <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (run) begin
              gates_executed <= '0;
              error          <= 1'b0;
              busy           <= 1'b1;
              if (!fifo_empty) begin
                state       <= S_ISSUE;
                gate_start  <= 1'b1;
                gate_type   <= head_cmd.gtype;
                gate_params <= head_cmd.params;
              end else begin
                state      <= S_DONE;
                done_pulse <= 1'b1;
              end
            end
          end
          S_ISSUE: begin
            state <= S_WAIT;
            timer <= '0;
          end
          S_WAIT: begin
            timer <= timer + 1'b1;
            if (result_valid) begin
              last_result <= result_data;
            end
            // gate_done is checked first so a completion on the final
            // timer cycle still counts as success.
            if (gate_done) begin
              if (gates_executed != '1) begin
                gates_executed <= gates_executed + 1'b1;
              end
              if (!fifo_empty) begin
                state       <= S_ISSUE;
                gate_start  <= 1'b1;
                gate_type   <= head_cmd.gtype;
                gate_params <= head_cmd.params;
              end else begin
                state      <= S_DONE;
                done_pulse <= 1'b1;
              end
            end else if (timer == TIMER_LAST) begin
              state <= S_ERROR;
              error <= 1'b1;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          S_ERROR: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gate_sequencer.sv
// Self-checking bench for gate_sequencer: reset values, a table of
// push/abort vectors, directed multi-cycle sequences, and randomized runs
// compared against a command-queue reference model.
module tb_gate_sequencer;
  import qaccel_pkg::*;

  localparam int unsigned DEPTH   = 16;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned CW      = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              push_valid = 1'b0;
  logic              push_ready;
  logic [1:0]        push_type = '0;
  logic [31:0]       push_params = '0;
  logic              run = 1'b0;
  logic              abort = 1'b0;
  logic              busy;
  logic              done_pulse;
  logic              error;
  logic [CNT_W-1:0]  gates_executed;
  logic [CW-1:0]     fifo_count;
  logic [31:0]       last_result;
  logic              gate_start;
  logic [1:0]        gate_type;
  logic [31:0]       gate_params;
  logic              gate_done = 1'b0;
  logic [31:0]       result_data = '0;
  logic              result_valid = 1'b0;

  gate_sequencer #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .push_valid     (push_valid),
    .push_ready     (push_ready),
    .push_type      (push_type),
    .push_params    (push_params),
    .run            (run),
    .abort          (abort),
    .busy           (busy),
    .done_pulse     (done_pulse),
    .error          (error),
    .gates_executed (gates_executed),
    .fifo_count     (fifo_count),
    .last_result    (last_result),
    .gate_start     (gate_start),
    .gate_type      (gate_type),
    .gate_params    (gate_params),
    .gate_done      (gate_done),
    .result_data    (result_data),
    .result_valid   (result_valid)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Core model state
  bit          core_en    = 1'b1;
  bit          core_busy  = 1'b0;
  bit          rv_noise   = 1'b0;
  bit          rand_delay = 1'b0;
  int          core_delay = 4;
  int          core_cnt   = 0;
  logic [31:0] core_res   = '0;
  logic [31:0] exp_last   = '0;
  logic [31:0] exp_last_prev = '0;

  // Per-run logs
  int          start_cyc[$];
  logic [1:0]  st_type[$];
  logic [31:0] st_par[$];
  int          gdone_cyc[$];
  int          done_cnt = 0;
  int          done_cyc = 0;

  typedef struct {
    logic        pv;
    logic [1:0]  t;
    logic [31:0] p;
    logic        ab;
    logic        rn;
    logic        exp_ready;
    int          exp_count;
    logic        exp_busy;
  } vec_t;

  vec_t        vecs [9];
  gate_cmd_t   q[$];
  gate_cmd_t   snap[$];
  gate_cmd_t   cmd;
  int          run_cyc, s, b, n, abort_at;
  bit          do_abort, aborted, exp_ready;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one clock, then observe outputs and drive the core's response
  // for the new cycle.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    exp_last_prev = exp_last;
    gate_done     = 1'b0;
    result_valid  = 1'b0;
    if (gate_start) begin
      start_cyc.push_back(cyc);
      st_type.push_back(gate_type);
      st_par.push_back(gate_params);
      core_busy = 1'b1;
      core_cnt  = rand_delay ? int'($urandom_range(1, 6)) : core_delay;
      core_res  = gate_params + 32'd1;
    end else if (core_busy && core_en) begin
      core_cnt--;
      if (core_cnt <= 0) begin
        gate_done    = 1'b1;
        result_valid = 1'b1;
        result_data  = core_res;
        core_busy    = 1'b0;
        gdone_cyc.push_back(cyc);
        exp_last     = core_res;
      end else if (rv_noise && $urandom_range(0, 3) == 0) begin
        result_valid = 1'b1;
        result_data  = $urandom;
        exp_last     = result_data;
      end
    end
    if (done_pulse) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic clear_logs();
    start_cyc.delete();
    st_type.delete();
    st_par.delete();
    gdone_cyc.delete();
    done_cnt = 0;
    done_cyc = 0;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    push_valid = 1'b0;
    run        = 1'b0;
    abort      = 1'b0;
    core_busy  = 1'b0;
    step();
    step();
    rst      = 1'b0;
    exp_last = '0;
  endtask

  task automatic push(input logic [1:0] t, input logic [31:0] p);
    push_valid  = 1'b1;
    push_type   = t;
    push_params = p;
    step();
    push_valid  = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done_cnt == 0 && k < budget) begin
      step();
      k++;
    end
    if (done_cnt == 0) check("run_finish_timeout", 0, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 2'd1, 32'h11, 1'b0, 1'b0, 1'b1, 1, 1'b0};
    vecs[1] = '{1'b1, 2'd2, 32'h22, 1'b0, 1'b0, 1'b1, 2, 1'b0};
    vecs[2] = '{1'b1, 2'd3, 32'h33, 1'b1, 1'b0, 1'b0, 0, 1'b0};
    vecs[3] = '{1'b0, 2'd0, 32'h00, 1'b0, 1'b0, 1'b1, 0, 1'b0};
    vecs[4] = '{1'b1, 2'd0, 32'h44, 1'b0, 1'b0, 1'b1, 1, 1'b0};
    vecs[5] = '{1'b1, 2'd1, 32'h45, 1'b1, 1'b1, 1'b0, 0, 1'b0};
    vecs[6] = '{1'b0, 2'd0, 32'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0};
    vecs[7] = '{1'b1, 2'd1, 32'h55, 1'b0, 1'b0, 1'b1, 1, 1'b0};
    vecs[8] = '{1'b0, 2'd0, 32'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0};

    // Reset values
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_done_pulse", done_pulse, 0);
    check("rst_error", error, 0);
    check("rst_gates", gates_executed, 0);
    check("rst_count", fifo_count, 0);
    check("rst_last", last_result, 0);
    check("rst_gate_start", gate_start, 0);
    check("rst_gate_type", gate_type, 0);
    check("rst_gate_params", gate_params, 0);
    check("rst_push_ready", push_ready, 1);

    // Table: push / abort / abort+run from IDLE
    for (int i = 0; i < 9; i++) begin
      push_valid  = vecs[i].pv;
      push_type   = vecs[i].t;
      push_params = vecs[i].p;
      abort       = vecs[i].ab;
      run         = vecs[i].rn;
      #1;
      check("tbl_ready", push_ready, vecs[i].exp_ready);
      step();
      push_valid = 1'b0;
      abort      = 1'b0;
      run        = 1'b0;
      check("tbl_count", fifo_count, vecs[i].exp_count);
      check("tbl_busy", busy, vecs[i].exp_busy);
    end

    // Three gates, core answers 4 cycles after each start
    clear_logs();
    core_delay = 4;
    push(2'd1, 32'hA);
    push(2'd2, 32'hB);
    push(2'd3, 32'hC);
    check("d2_count", fifo_count, 3);
    run = 1'b1;
    step();
    run = 1'b0;
    run_cyc = cyc;
    wait_done(200);
    check("d2_starts", start_cyc.size(), 3);
    for (int i = 0; i < start_cyc.size() && i < 3; i++) begin
      check("d2_type", st_type[i], i + 1);
      check("d2_params", st_par[i], 32'hA + i);
      if (i == 0) check("d2_lat_run", start_cyc[0], run_cyc);
      else if (gdone_cyc.size() >= i) check("d2_lat_done", start_cyc[i], gdone_cyc[i-1] + 1);
    end
    check("d2_done_pulses", done_cnt, 1);
    check("d2_gates", gates_executed, 3);
    check("d2_last", last_result, 32'hD);
    step();
    check("d2_busy_after", busy, 0);
    check("d2_pulse_width", done_cnt, 1);

    // Zero-gate run
    clear_logs();
    run = 1'b1;
    step();
    run = 1'b0;
    check("d3_done_pulse", done_pulse, 1);
    check("d3_busy", busy, 1);
    check("d3_gates_cleared", gates_executed, 0);
    step();
    check("d3_pulse_off", done_pulse, 0);
    check("d3_busy_after", busy, 0);
    check("d3_no_start", start_cyc.size(), 0);

    // Timeout: core never completes
    clear_logs();
    core_en = 1'b0;
    push(2'd0, 32'h77);
    push(2'd1, 32'h78);
    run = 1'b1;
    step();
    run = 1'b0;
    s = cyc;
    check("d4_start", gate_start, 1);
    while (cyc < s + TIMEOUT) step();
    check("d4_err_early", error, 0);
    check("d4_busy_wait", busy, 1);
    step();
    check("d4_err", error, 1);
    step();
    check("d4_err_sticky", error, 1);
    check("d4_flushed", fifo_count, 0);
    check("d4_idle", busy, 0);
    check("d4_no_done", done_cnt, 0);
    check("d4_gates", gates_executed, 0);
    core_en   = 1'b1;
    core_busy = 1'b0;
    run = 1'b1;
    step();
    run = 1'b0;
    check("d4_err_cleared", error, 0);
    check("d4_rerun_done", done_pulse, 1);
    step();

    // Full FIFO, dropped push, push alongside the first pop
    clear_logs();
    core_delay = 1;
    q.delete();
    for (int i = 0; i < 16; i++) begin
      push_valid  = 1'b1;
      push_type   = 2'(i);
      push_params = 32'h100 + i;
      #1;
      check("d5_ready", push_ready, 1);
      step();
      cmd.gtype  = 2'(i);
      cmd.params = 32'h100 + i;
      q.push_back(cmd);
    end
    push_type   = 2'd3;
    push_params = 32'h1FF;
    #1;
    check("d5_full_ready", push_ready, 0);
    step();
    push_valid = 1'b0;
    check("d5_count_full", fifo_count, 16);
    run         = 1'b1;
    push_valid  = 1'b1;
    push_type   = 2'd2;
    push_params = 32'h200;
    #1;
    check("d5_ready_on_pop", push_ready, 1);
    step();
    run        = 1'b0;
    push_valid = 1'b0;
    cmd.gtype  = 2'd2;
    cmd.params = 32'h200;
    q.push_back(cmd);
    check("d5_count_hold", fifo_count, 16);
    wait_done(400);
    check("d5_starts", start_cyc.size(), 17);
    for (int i = 0; i < start_cyc.size() && i < q.size(); i++) begin
      check("d5_type", st_type[i], q[i].gtype);
      check("d5_params", st_par[i], q[i].params);
    end
    check("d5_gates", gates_executed, 17);
    check("d5_done_pulses", done_cnt, 1);
    step();

    // Abort during WAIT of the 2nd of 4 gates, then a late gate_done
    clear_logs();
    core_delay = 4;
    for (int i = 0; i < 4; i++) push(2'(i), 32'h10 + i);
    run = 1'b1;
    step();
    run = 1'b0;
    b = 0;
    while (start_cyc.size() < 2 && b < 100) begin
      step();
      b++;
    end
    check("d6_second_start", start_cyc.size(), 2);
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("d6_idle", busy, 0);
    check("d6_flushed", fifo_count, 0);
    check("d6_gates", gates_executed, 1);
    repeat (6) step();
    check("d6_gates_late", gates_executed, 1);
    check("d6_last_late", last_result, 32'h11);
    check("d6_no_more_start", start_cyc.size(), 2);
    check("d6_no_done", done_cnt, 0);
    check("d6_still_idle", busy, 0);

    // Reset in the middle of a run
    do_reset();
    clear_logs();
    core_delay = 4;
    push(2'd3, 32'h31);
    push(2'd2, 32'h32);
    push(2'd1, 32'h33);
    run = 1'b1;
    step();
    run = 1'b0;
    b = 0;
    while (start_cyc.size() < 2 && b < 100) begin
      step();
      b++;
    end
    check("d7_pre_gates", gates_executed, 1);
    step();
    rst       = 1'b1;
    core_busy = 1'b0;
    step();
    check("d7_busy", busy, 0);
    check("d7_error", error, 0);
    check("d7_gates", gates_executed, 0);
    check("d7_count", fifo_count, 0);
    check("d7_last", last_result, 0);
    check("d7_gate_start", gate_start, 0);
    check("d7_gate_type", gate_type, 0);
    check("d7_gate_params", gate_params, 0);
    check("d7_push_ready", push_ready, 1);
    rst = 1'b0;
    step();
    check("d7_count_after", fifo_count, 0);
    check("d7_idle_after", busy, 0);

    // Randomized runs against a command-queue model
    do_reset();
    rv_noise   = 1'b1;
    rand_delay = 1'b1;
    for (int it = 0; it < 40; it++) begin
      q.delete();
      clear_logs();
      n = $urandom_range(0, 18);
      for (int i = 0; i < n; i++) begin
        push_valid  = 1'b1;
        push_type   = 2'($urandom_range(0, 3));
        push_params = $urandom;
        #1;
        exp_ready = (q.size() < DEPTH);
        check("rnd_ready", push_ready, exp_ready);
        cmd.gtype  = push_type;
        cmd.params = push_params;
        step();
        if (exp_ready) q.push_back(cmd);
      end
      push_valid = 1'b0;
      check("rnd_count", fifo_count, q.size());
      snap = q;
      do_abort = (q.size() > 0) && ($urandom_range(0, 3) == 0);
      abort_at = (q.size() > 0) ? int'($urandom_range(1, q.size())) : 1;
      aborted  = 1'b0;
      run = 1'b1;
      step();
      run = 1'b0;
      run_cyc = cyc;
      b = 0;
      while (done_cnt == 0 && !aborted && b < 400) begin
        if (do_abort && core_busy && !gate_done && start_cyc.size() >= abort_at &&
            $urandom_range(0, 2) == 0) begin
          abort        = 1'b1;
          result_valid = 1'b0;
          exp_last     = exp_last_prev;
          core_busy    = 1'b0;
          aborted      = 1'b1;
        end
        step();
        abort = 1'b0;
        b++;
      end
      if (done_cnt == 0 && !aborted) check("rnd_run_timeout", 0, 1);
      for (int i = 0; i < start_cyc.size() && i < snap.size(); i++) begin
        check("rnd_type", st_type[i], snap[i].gtype);
        check("rnd_params", st_par[i], snap[i].params);
        if (i == 0) check("rnd_lat_run", start_cyc[0], run_cyc);
        else if (gdone_cyc.size() >= i) check("rnd_lat_done", start_cyc[i], gdone_cyc[i-1] + 1);
      end
      check("rnd_last", last_result, exp_last);
      check("rnd_error", error, 0);
      check("rnd_flushed", fifo_count, 0);
      if (aborted) begin
        check("rnd_abort_idle", busy, 0);
        check("rnd_abort_no_done", done_cnt, 0);
        check("rnd_abort_gates", gates_executed, gdone_cyc.size());
        check("rnd_abort_starts_le", start_cyc.size() <= snap.size(), 1);
      end else begin
        check("rnd_starts", start_cyc.size(), snap.size());
        check("rnd_gates", gates_executed, snap.size());
        check("rnd_done_pulses", done_cnt, 1);
        if (snap.size() > 0) begin
          check("rnd_last_model", last_result, snap[snap.size()-1].params + 32'd1);
          check("rnd_done_lat", done_cyc, gdone_cyc[gdone_cyc.size()-1] + 1);
        end else begin
          check("rnd_zero_done_lat", done_cyc, run_cyc);
        end
        step();
        check("rnd_busy_after", busy, 0);
      end
      repeat ($urandom_range(0, 3)) step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
